// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared state encoding and branch-type codes for the redirect controller
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2,
        S_TRAP     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2,
        BR_BR   = 2'd3
    } br_type_e;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/branch_redirect_ctrl_flush_counter.sv
// rtl/branch_redirect_ctrl_flush_counter.sv - loadable down-counter timing the post-redirect IF/ID flush
module branch_redirect_ctrl_flush_counter
    import branch_redirect_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [FLUSH_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   done
);

    logic [FLUSH_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Done marks the last flush cycle, so the FSM leaves FLUSH on that edge.
    assign done = (count == FLUSH_CNT_W'(1));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - taken-branch PC redirect handshake and IF/ID, ID/EX squash sequencing
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              FLUSH_STAGES = 2,
    parameter logic [XLEN-1:0] RESET_PC     = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic            i_is_branching,
    input  logic [XLEN-1:0] i_branch_addr,
    input  logic            i_stall,
    input  logic            i_if_ready,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush_if_id,
    output logic            o_flush_id_ex,
    output logic            o_misalign_trap,
    output logic [XLEN-1:0] o_trap_addr,
    output logic            o_busy
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_STAGES);
    localparam bit                     HAS_FLUSH  = (FLUSH_STAGES > 0);

    state_e            state;
    state_e            state_nx;
    logic              valid_nx;
    logic              flush_if_id_nx;
    logic              flush_id_ex_nx;
    logic              trap_nx;
    logic [XLEN-1:0]   pc_nx;
    logic [XLEN-1:0]   trap_addr_nx;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_done;
    logic              capture;

    assign capture = i_ex_valid && i_is_branching && !i_stall;

    branch_redirect_ctrl_flush_counter u_flush_counter (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (cnt_load),
        .load_val (FLUSH_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Outputs are computed one cycle ahead and registered alongside the state.
    always_comb begin
        state_nx       = state;
        valid_nx       = 1'b0;
        flush_if_id_nx = 1'b0;
        flush_id_ex_nx = 1'b0;
        trap_nx        = 1'b0;
        pc_nx          = o_redirect_pc;
        trap_addr_nx   = o_trap_addr;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;

        case (state)
            S_IDLE: begin
                if (capture) begin
                    flush_if_id_nx = 1'b1;
                    flush_id_ex_nx = 1'b1;
                    if (i_branch_addr[1]) begin
                        state_nx     = S_TRAP;
                        trap_nx      = 1'b1;
                        trap_addr_nx = i_branch_addr;
                    end else begin
                        state_nx = S_REDIRECT;
                        valid_nx = 1'b1;
                        pc_nx    = i_branch_addr;
                    end
                end
            end
            S_REDIRECT: begin
                if (i_if_ready) begin
                    if (HAS_FLUSH) begin
                        state_nx       = S_FLUSH;
                        cnt_load       = 1'b1;
                        flush_if_id_nx = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    valid_nx       = 1'b1;
                    flush_if_id_nx = 1'b1;
                    flush_id_ex_nx = 1'b1;
                end
            end
            S_FLUSH: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_nx = S_IDLE;
                end else begin
                    flush_if_id_nx = 1'b1;
                end
            end
            S_TRAP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= RESET_PC;
            o_flush_if_id    <= 1'b0;
            o_flush_id_ex    <= 1'b0;
            o_misalign_trap  <= 1'b0;
            o_trap_addr      <= '0;
            o_busy           <= 1'b0;
        end else begin
            state            <= state_nx;
            o_redirect_valid <= valid_nx;
            o_redirect_pc    <= pc_nx;
            o_flush_if_id    <= flush_if_id_nx;
            o_flush_id_ex    <= flush_id_ex_nx;
            o_misalign_trap  <= trap_nx;
            o_trap_addr      <= trap_addr_nx;
            o_busy           <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl (FLUSH_STAGES 2 and 0 builds)
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ex_valid = 1'b0, is_br = 1'b0, stall = 1'b0, if_ready = 1'b0;
    logic [31:0] br_addr = '0;
    logic        r_valid, f_if_id, f_id_ex, m_trap, busy;
    logic [31:0] r_pc, t_addr;

    logic        b_ex_valid = 1'b0, b_is_br = 1'b0, b_stall = 1'b0, b_if_ready = 1'b0;
    logic [31:0] b_br_addr = '0;
    logic        b_r_valid, b_f_if_id, b_f_id_ex, b_m_trap, b_busy;
    logic [31:0] b_r_pc, b_t_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_redir[$];
    logic [31:0] exp_trap[$];
    logic [31:0] exp_redir0[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_STAGES(2), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_is_branching(is_br),
        .i_branch_addr(br_addr), .i_stall(stall), .i_if_ready(if_ready),
        .o_redirect_valid(r_valid), .o_redirect_pc(r_pc), .o_flush_if_id(f_if_id),
        .o_flush_id_ex(f_id_ex), .o_misalign_trap(m_trap), .o_trap_addr(t_addr), .o_busy(busy)
    );

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_STAGES(0), .RESET_PC(32'h0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(b_ex_valid), .i_is_branching(b_is_br),
        .i_branch_addr(b_br_addr), .i_stall(b_stall), .i_if_ready(b_if_ready),
        .o_redirect_valid(b_r_valid), .o_redirect_pc(b_r_pc), .o_flush_if_id(b_f_if_id),
        .o_flush_id_ex(b_f_id_ex), .o_misalign_trap(b_m_trap), .o_trap_addr(b_t_addr), .o_busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic fi, input logic fe,
                             input logic tr, input logic bz);
        chk({tag, ".valid"}, {31'd0, r_valid}, {31'd0, v});
        chk({tag, ".flush_if_id"}, {31'd0, f_if_id}, {31'd0, fi});
        chk({tag, ".flush_id_ex"}, {31'd0, f_id_ex}, {31'd0, fe});
        chk({tag, ".trap"}, {31'd0, m_trap}, {31'd0, tr});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    endtask

    task automatic chk_flags0(input string tag, input logic v, input logic fi, input logic fe,
                              input logic bz);
        chk({tag, ".valid"}, {31'd0, b_r_valid}, {31'd0, v});
        chk({tag, ".flush_if_id"}, {31'd0, b_f_if_id}, {31'd0, fi});
        chk({tag, ".flush_id_ex"}, {31'd0, b_f_id_ex}, {31'd0, fe});
        chk({tag, ".busy"}, {31'd0, b_busy}, {31'd0, bz});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each redirect handshake and each trap pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (r_valid && if_ready) begin
                if (exp_redir.size() == 0) chk("unexpected_redirect", r_pc, 32'hdead_beef);
                else chk("redirect_pc", r_pc, exp_redir.pop_front());
            end
            if (m_trap) begin
                if (exp_trap.size() == 0) chk("unexpected_trap", t_addr, 32'hdead_beef);
                else chk("trap_addr", t_addr, exp_trap.pop_front());
            end
            if (b_r_valid && b_if_ready) begin
                if (exp_redir0.size() == 0) chk("unexpected_redirect0", b_r_pc, 32'hdead_beef);
                else chk("redirect0_pc", b_r_pc, exp_redir0.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then reset hitting while in REDIRECT
        rst = 1'b1;
        tick();
        tick();
        chk_flags("rst", 0, 0, 0, 0, 0);
        chk("rst.pc", r_pc, 32'h0);
        chk("rst.trap_addr", t_addr, 32'h0);
        rst = 1'b0;
        ex_valid = 1'b1; is_br = 1'b1; br_addr = 32'h0000_0080; if_ready = 1'b0;
        tick();
        is_br = 1'b0;
        chk_flags("pre_rst_redirect", 1, 1, 1, 0, 1);
        rst = 1'b1;
        tick();
        chk_flags("mid_rst", 0, 0, 0, 0, 0);
        chk("mid_rst.pc", r_pc, 32'h0);
        rst = 1'b0;
        tick();

        // 2: JAL to 0x100, fetch ready immediately
        is_br = 1'b1; br_addr = 32'h0000_0100; if_ready = 1'b1;
        exp_redir.push_back(32'h0000_0100);
        tick();
        is_br = 1'b0;
        chk_flags("jal.t1", 1, 1, 1, 0, 1);
        chk("jal.t1.pc", r_pc, 32'h0000_0100);
        tick();
        chk_flags("jal.t2", 0, 1, 0, 0, 1);
        tick();
        chk_flags("jal.t3", 0, 1, 0, 0, 1);
        tick();
        chk_flags("jal.t4", 0, 0, 0, 0, 0);
        chk("jal.t4.pc_held", r_pc, 32'h0000_0100);

        // 3: target 0x200 with fetch backpressure for 3 cycles
        is_br = 1'b1; br_addr = 32'h0000_0200; if_ready = 1'b0;
        exp_redir.push_back(32'h0000_0200);
        tick();
        is_br = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_flags($sformatf("bp.hold%0d", k), 1, 1, 1, 0, 1);
            chk($sformatf("bp.hold%0d.pc", k), r_pc, 32'h0000_0200);
            tick();
        end
        chk_flags("bp.hs", 1, 1, 1, 0, 1);
        if_ready = 1'b1;
        tick();
        chk_flags("bp.flush1", 0, 1, 0, 0, 1);
        tick();
        chk_flags("bp.flush2", 0, 1, 0, 0, 1);
        tick();
        chk_flags("bp.idle", 0, 0, 0, 0, 0);

        // 4: misaligned target
        is_br = 1'b1; br_addr = 32'h0000_0102;
        exp_trap.push_back(32'h0000_0102);
        tick();
        is_br = 1'b0;
        chk_flags("mis.t1", 0, 1, 1, 1, 1);
        chk("mis.t1.trap_addr", t_addr, 32'h0000_0102);
        tick();
        chk_flags("mis.t2", 0, 0, 0, 0, 0);
        chk("mis.t2.trap_addr_held", t_addr, 32'h0000_0102);
        chk("mis.t2.pc_unchanged", r_pc, 32'h0000_0200);

        // bubble in EX does not capture
        ex_valid = 1'b0; is_br = 1'b1; br_addr = 32'h0000_0700;
        tick();
        chk_flags("bubble", 0, 0, 0, 0, 0);
        ex_valid = 1'b1;

        // 5: stalled branch, then a wrong-path pulse during FLUSH
        stall = 1'b1; br_addr = 32'h0000_0300;
        tick();
        chk_flags("stall.c1", 0, 0, 0, 0, 0);
        tick();
        chk_flags("stall.c2", 0, 0, 0, 0, 0);
        stall = 1'b0;
        exp_redir.push_back(32'h0000_0300);
        tick();
        chk_flags("stall.cap", 1, 1, 1, 0, 1);
        chk("stall.cap.pc", r_pc, 32'h0000_0300);
        br_addr = 32'h0000_0400;
        tick();
        chk_flags("wp.flush1", 0, 1, 0, 0, 1);
        tick();
        chk_flags("wp.flush2", 0, 1, 0, 0, 1);
        is_br = 1'b0;
        tick();
        chk_flags("wp.idle", 0, 0, 0, 0, 0);
        chk("wp.pc_held", r_pc, 32'h0000_0300);

        // 6: FLUSH_STAGES=0 build, redirects two cycles apart
        b_ex_valid = 1'b1; b_is_br = 1'b1; b_br_addr = 32'h0000_0500; b_if_ready = 1'b1;
        exp_redir0.push_back(32'h0000_0500);
        tick();
        b_is_br = 1'b0;
        chk_flags0("fs0.t1", 1, 1, 1, 1);
        chk("fs0.t1.pc", b_r_pc, 32'h0000_0500);
        tick();
        chk_flags0("fs0.t2", 0, 0, 0, 0);
        b_is_br = 1'b1; b_br_addr = 32'h0000_0600;
        exp_redir0.push_back(32'h0000_0600);
        tick();
        b_is_br = 1'b0;
        chk_flags0("fs0.t3", 1, 1, 1, 1);
        chk("fs0.t3.pc", b_r_pc, 32'h0000_0600);
        tick();
        chk_flags0("fs0.t4", 0, 0, 0, 0);

        for (int w = 0; w < 10; w++) begin
            if (exp_redir.size() == 0 && exp_trap.size() == 0 && exp_redir0.size() == 0) break;
            tick();
        end
        chk("sb.redir_left", 32'(exp_redir.size()), 32'd0);
        chk("sb.trap_left", 32'(exp_trap.size()), 32'd0);
        chk("sb.redir0_left", 32'(exp_redir0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
